// File: rtl/uart_reg_file_pkg.sv
// Shared types and constants for the uart_reg_file register slave.
// Holds the grant FSM state encoding and the read-only ID value.
package uart_reg_file_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_GRANT = 2'd2
  } gnt_state_e;

  localparam logic [7:0] UART_REG_ID = 8'hA5;

endpackage

// File: rtl/uart_reg_file_if.sv
// Bus between the uart2bus master and the register-file slave:
// req/gnt handshake plus single-cycle read/write strobes.
interface uart_reg_file_if #(
  parameter int ADDR_W = 8
);
  logic              req;
  logic              gnt;
  logic [ADDR_W-1:0] addr;
  logic              wen;
  logic [7:0]        wdata;
  logic              ren;
  logic [7:0]        rdata;

  modport master (output req, addr, wen, wdata, ren, input gnt, rdata);
  modport slave  (input req, addr, wen, wdata, ren, output gnt, rdata);
endinterface

// File: rtl/uart_bus_gnt.sv
// Grant FSM for the register-file bus. gnt_o is registered and rises
// GNT_DELAY+1 edges after req_i is first sampled high.
//
//   state   | meaning
//   S_IDLE  | no request, gnt_o low
//   S_WAIT  | request seen, delay counter running down
//   S_GRANT | bus granted while req_i stays high
module uart_bus_gnt
  import uart_reg_file_pkg::*;
#(
  parameter int GNT_DELAY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  output logic gnt_o
);

  localparam logic [3:0] CNT_LOAD = (GNT_DELAY > 0) ? 4'(GNT_DELAY - 1) : 4'd0;

  gnt_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gnt_q, gnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (GNT_DELAY == 0) begin
            state_d = S_GRANT;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!req_i)              state_d = S_IDLE;
        else if (cnt_q == 4'd0)  state_d = S_GRANT;
        else                     cnt_d   = cnt_q - 4'd1;
      end
      S_GRANT: begin
        if (!req_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Grant is decoded from the next state so the output is a clean flop.
    gnt_d = (state_d == S_GRANT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt_o = gnt_q;

endmodule

// File: rtl/uart_reg_file.sv
// Byte register bank behind the uart2bus master with registered reads,
// sticky protocol-error flag and reg[0] exported as ctrl_o.
// Optional UART_REG_FILE_ID_EN makes address DEPTH-1 a read-only ID register.
module uart_reg_file
  import uart_reg_file_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 64,
  parameter int GNT_DELAY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_reg_file_if.slave  bus,
  output logic [7:0]      ctrl_o,
  output logic            err_o,
  input  logic            err_clr_i
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic             gnt;
  logic [7:0]       regs_q [DEPTH];
  logic [7:0]       regs_d [DEPTH];
  logic [7:0]       rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] idx;
  logic             addr_ok;
  logic             is_id;

  uart_bus_gnt #(.GNT_DELAY(GNT_DELAY)) u_bus_gnt (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (bus.req),
    .gnt_o (gnt)
  );

  assign idx     = bus.addr[IDX_W-1:0];
  assign addr_ok = {1'b0, bus.addr} < DEPTH_W;

`ifdef UART_REG_FILE_ID_EN
  assign is_id = addr_ok && (idx == IDX_W'(DEPTH - 1));
`else
  assign is_id = 1'b0;
`endif

  always_comb begin
    regs_d  = regs_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (err_clr_i) err_d = 1'b0;
    // Error set comes after clear so a same-cycle set wins.
    if (bus.wen || bus.ren) begin
      if (!gnt) begin
        err_d = 1'b1;
      end else begin
        if (!addr_ok) err_d = 1'b1;
        if (bus.ren) begin
          if (!addr_ok)   rdata_d = 8'h00;
          else if (is_id) rdata_d = UART_REG_ID;
          else            rdata_d = regs_q[idx];
        end
        if (bus.wen && addr_ok && !is_id) regs_d[idx] = bus.wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.gnt   = gnt;
  assign bus.rdata = rdata_q;
  assign ctrl_o    = regs_q[0];
  assign err_o     = err_q;

endmodule

// File: tb/tb_uart_reg_file.sv
// Directed bench for uart_reg_file: grant timing, read/write, ctrl_o,
// reset, error flag, read-before-write and the top-address behaviour.
module tb_uart_reg_file;

  logic       clk;
  logic       rst_n;
  logic [7:0] ctrl_o;
  logic       err_o;
  logic       err_clr_i;
  int         vec_cnt = 0;
  int         err_cnt = 0;

  uart_reg_file_if #(.ADDR_W(8)) bus ();

  uart_reg_file #(.ADDR_W(8), .DEPTH(64), .GNT_DELAY(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ctrl_o    (ctrl_o),
    .err_o     (err_o),
    .err_clr_i (err_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acquire();
    bus.req = 1'b1;
    repeat (3) tick();
  endtask

  task automatic release_bus();
    bus.req = 1'b0;
    tick();
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    bus.addr = a; bus.wdata = d; bus.wen = 1'b1;
    tick();
    bus.wen = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a);
    bus.addr = a; bus.ren = 1'b1;
    tick();
    bus.ren = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; err_clr_i = 1'b0;
    bus.req = 1'b0; bus.wen = 1'b0; bus.ren = 1'b0;
    bus.addr = 8'h00; bus.wdata = 8'h00;
    repeat (2) tick();
    vec_cnt++;
    if (bus.gnt !== 1'b0) begin err_cnt++; $display("FAIL reset_gnt got %b want 0", bus.gnt); end
    vec_cnt++;
    if (bus.rdata !== 8'h00) begin err_cnt++; $display("FAIL reset_rdata got %h want 00", bus.rdata); end
    vec_cnt++;
    if (ctrl_o !== 8'h00) begin err_cnt++; $display("FAIL reset_ctrl got %h want 00", ctrl_o); end
    vec_cnt++;
    if (err_o !== 1'b0) begin err_cnt++; $display("FAIL reset_err got %b want 0", err_o); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_grant_timing();
    logic [3:0] exp_gnt;
    exp_gnt = 4'b0100;
    bus.req = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      vec_cnt++;
      if (bus.gnt !== exp_gnt[e]) begin
        err_cnt++; $display("FAIL grant_edge%0d got %b want %b", e + 1, bus.gnt, exp_gnt[e]);
      end
    end
    bus.req = 1'b0;
    tick();
    vec_cnt++;
    if (bus.gnt !== 1'b0) begin err_cnt++; $display("FAIL grant_drop got %b want 0", bus.gnt); end
  endtask

  task automatic test_write_read();
    acquire();
    vec_cnt++;
    if (bus.gnt !== 1'b1) begin err_cnt++; $display("FAIL wr_gnt got %b want 1", bus.gnt); end
    do_write(8'h3d, 8'h1a);
    do_read(8'h3d);
    vec_cnt++;
    if (bus.rdata !== 8'h1a) begin err_cnt++; $display("FAIL rd_3d got %h want 1a", bus.rdata); end
    vec_cnt++;
    if (err_o !== 1'b0) begin err_cnt++; $display("FAIL wr_err got %b want 0", err_o); end
  endtask

  task automatic test_ctrl_and_reset();
    do_write(8'h00, 8'h55);
    vec_cnt++;
    if (ctrl_o !== 8'h55) begin err_cnt++; $display("FAIL ctrl_55 got %h want 55", ctrl_o); end
    bus.req = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vec_cnt++;
    if (ctrl_o !== 8'h00) begin err_cnt++; $display("FAIL rst_ctrl got %h want 00", ctrl_o); end
    vec_cnt++;
    if (bus.rdata !== 8'h00) begin err_cnt++; $display("FAIL rst_rdata got %h want 00", bus.rdata); end
    acquire();
    do_read(8'h3d);
    vec_cnt++;
    if (bus.rdata !== 8'h00) begin err_cnt++; $display("FAIL rst_reg3d got %h want 00", bus.rdata); end
  endtask

  task automatic test_errors();
    do_write(8'h3d, 8'h77);
    do_write(8'h10, 8'h66);
    do_write(8'hff, 8'h12);
    vec_cnt++;
    if (err_o !== 1'b1) begin err_cnt++; $display("FAIL oor_wr_err got %b want 1", err_o); end
    do_read(8'hff);
    vec_cnt++;
    if (bus.rdata !== 8'h00) begin err_cnt++; $display("FAIL oor_rd got %h want 00", bus.rdata); end
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    vec_cnt++;
    if (err_o !== 1'b0) begin err_cnt++; $display("FAIL err_clr got %b want 0", err_o); end
    do_read(8'h3f);
    vec_cnt++;
    if (bus.rdata !== 8'h00) begin err_cnt++; $display("FAIL alias_3f got %h want 00", bus.rdata); end
    do_read(8'h3d);
    vec_cnt++;
    if (bus.rdata !== 8'h77) begin err_cnt++; $display("FAIL rd_77 got %h want 77", bus.rdata); end
    release_bus();
    vec_cnt++;
    if (bus.gnt !== 1'b0) begin err_cnt++; $display("FAIL released got %b want 0", bus.gnt); end
    do_read(8'h10);
    vec_cnt++;
    if (err_o !== 1'b1) begin err_cnt++; $display("FAIL ungnt_rd_err got %b want 1", err_o); end
    vec_cnt++;
    if (bus.rdata !== 8'h77) begin err_cnt++; $display("FAIL ungnt_rdata got %h want 77", bus.rdata); end
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    vec_cnt++;
    if (err_o !== 1'b0) begin err_cnt++; $display("FAIL err_clr2 got %b want 0", err_o); end
    err_clr_i = 1'b1;
    do_write(8'h3d, 8'h99);
    err_clr_i = 1'b0;
    vec_cnt++;
    if (err_o !== 1'b1) begin err_cnt++; $display("FAIL set_over_clr got %b want 1", err_o); end
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    acquire();
    do_read(8'h3d);
    vec_cnt++;
    if (bus.rdata !== 8'h77) begin err_cnt++; $display("FAIL ungnt_wr_ignored got %h want 77", bus.rdata); end
    vec_cnt++;
    if (err_o !== 1'b0) begin err_cnt++; $display("FAIL err_after got %b want 0", err_o); end
  endtask

  task automatic test_rd_before_wr();
    do_write(8'h05, 8'h11);
    bus.addr = 8'h05; bus.wdata = 8'h22; bus.wen = 1'b1; bus.ren = 1'b1;
    tick();
    bus.wen = 1'b0; bus.ren = 1'b0;
    vec_cnt++;
    if (bus.rdata !== 8'h11) begin err_cnt++; $display("FAIL rbw_old got %h want 11", bus.rdata); end
    do_read(8'h05);
    vec_cnt++;
    if (bus.rdata !== 8'h22) begin err_cnt++; $display("FAIL rbw_new got %h want 22", bus.rdata); end
  endtask

  task automatic test_top_addr();
    logic [7:0] exp_top;
`ifdef UART_REG_FILE_ID_EN
    exp_top = 8'hA5;
`else
    exp_top = 8'h00;
`endif
    do_write(8'h3f, 8'h33);
    do_write(8'h3f, 8'h00);
    do_read(8'h3f);
    vec_cnt++;
    if (bus.rdata !== exp_top) begin err_cnt++; $display("FAIL top_addr got %h want %h", bus.rdata, exp_top); end
    vec_cnt++;
    if (err_o !== 1'b0) begin err_cnt++; $display("FAIL top_err got %b want 0", err_o); end
    release_bus();
  endtask

  initial begin
    test_reset();
    test_grant_timing();
    test_write_read();
    test_ctrl_and_reset();
    test_errors();
    test_rd_before_wr();
    test_top_addr();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
